// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: default data-bus width,
// FSM state encoding and step-counter width.
package div_unit_pkg;

  localparam int DATA_BUS_W = 32;
  localparam int DIV_MAX_W  = 64;
  localparam int STEP_CNT_W = $clog2(DIV_MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Index of the final restoring step for a given operand width.
  function automatic logic [STEP_CNT_W-1:0] last_step(input int width);
    return STEP_CNT_W'(width - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step: shift in the next dividend bit, trial
// subtract the divisor on a one-bit-wider datapath, keep or restore.
module div_step
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_W
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] quo_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] quo_out
);

  logic [DATA_WIDTH:0] shifted_s;
  logic [DATA_WIDTH:0] diff_s;

  // Trial subtract; a set top bit of the difference means the divisor did not fit.
  always_comb begin
    shifted_s = {rem_in, quo_in[DATA_WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[DATA_WIDTH]) begin
      rem_out = shifted_s[DATA_WIDTH-1:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff_s[DATA_WIDTH-1:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider with IDLE/BUSY/DONE control and pipeline stall.
// Define DIV_SIGNED_EN to add the is_signed port and signed division.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef DIV_SIGNED_EN
  input  logic                  is_signed,
`endif
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam logic [STEP_CNT_W-1:0] LAST_STEP = last_step(DATA_WIDTH);

  div_state_e              state_r;
  logic [STEP_CNT_W-1:0]   step_cnt_r;
  logic [DATA_WIDTH-1:0]   rem_r;
  logic [DATA_WIDTH-1:0]   quo_r;
  logic [DATA_WIDTH-1:0]   divisor_r;
  logic [DATA_WIDTH-1:0]   step_rem_s;
  logic [DATA_WIDTH-1:0]   step_quo_s;
  logic [DATA_WIDTH-1:0]   mag_1_s;
  logic [DATA_WIDTH-1:0]   mag_2_s;
  logic [DATA_WIDTH-1:0]   quo_fix_s;
  logic [DATA_WIDTH-1:0]   rem_fix_s;
  logic                    accept_s;

  assign accept_s  = start & (state_r != ST_BUSY) & ~flush;
  assign stall_req = (state_r == ST_BUSY) | accept_s;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

`ifdef DIV_SIGNED_EN
  logic neg_quo_r;
  logic neg_rem_r;

  // Divide magnitudes; the most negative value maps onto itself, read as unsigned.
  always_comb begin
    if (is_signed && operand_1[DATA_WIDTH-1]) begin
      mag_1_s = '0 - operand_1;
    end else begin
      mag_1_s = operand_1;
    end
    if (is_signed && operand_2[DATA_WIDTH-1]) begin
      mag_2_s = '0 - operand_2;
    end else begin
      mag_2_s = operand_2;
    end
    if (neg_quo_r) begin
      quo_fix_s = '0 - step_quo_s;
    end else begin
      quo_fix_s = step_quo_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = '0 - step_rem_s;
    end else begin
      rem_fix_s = step_rem_s;
    end
  end

  // Result signs captured with the operands on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      neg_quo_r <= is_signed & (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]);
      neg_rem_r <= is_signed & operand_1[DATA_WIDTH-1];
    end else begin
      neg_quo_r <= neg_quo_r;
      neg_rem_r <= neg_rem_r;
    end
  end
`else
  assign mag_1_s   = operand_1;
  assign mag_2_s   = operand_2;
  assign quo_fix_s = step_quo_s;
  assign rem_fix_s = step_rem_s;
`endif

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      step_cnt_r <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      divisor_r  <= '0;
      done       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
    end else if (flush) begin
      state_r    <= ST_IDLE;
      step_cnt_r <= '0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rem_r      <= '0;
            quo_r      <= mag_1_s;
            divisor_r  <= mag_2_s;
            step_cnt_r <= '0;
            if (operand_2 == '0) begin
              state_r   <= ST_DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= operand_1;
              div_zero  <= 1'b1;
            end else begin
              state_r <= ST_BUSY;
              done    <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
          end
        end
        ST_BUSY: begin
          rem_r <= step_rem_s;
          quo_r <= step_quo_s;
          if (step_cnt_r == LAST_STEP) begin
            state_r    <= ST_DONE;
            step_cnt_r <= '0;
            done       <= 1'b1;
            quotient   <= quo_fix_s;
            remainder  <= rem_fix_s;
            div_zero   <= 1'b0;
          end else begin
            step_cnt_r <= step_cnt_r + STEP_CNT_W'(1);
            done       <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          step_cnt_r <= '0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, randomized ops against an
// arithmetic reference, and hand-built flush / back-to-back / reset sequences.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
`ifdef DIV_SIGNED_EN
  logic         is_signed;
`endif
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         stall_req;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    bit           sg;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef DIV_SIGNED_EN
    .is_signed (is_signed),
`endif
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic plus the zero-divisor and overflow rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == '0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (sg) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int lat;
    int exp_lat;
    bit seen;
    bit stall_ok;
    exp_lat = (b == '0) ? 1 : W + 1;
    @(negedge clk);
    operand_1 = a;
    operand_2 = b;
    start     = 1'b1;
`ifdef DIV_SIGNED_EN
    is_signed = sg;
`endif
    #1 stall_ok = (stall_req === 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) seen = 1'b1;
      else if (stall_req !== 1'b1) stall_ok = 1'b0;
      start = 1'b0;
    end
    check("done_seen", W'(seen), W'(1));
    check("latency", W'(lat), W'(exp_lat));
    check("stall_while_busy", W'(stall_ok), W'(1));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", W'(div_zero), W'(edz));
    @(negedge clk);
    check("done_single_pulse", W'(done), W'(0));
    check("quotient_held", quotient, eq);
  endtask

  initial begin
    logic [W-1:0] a, b, q, r, q1, r1, q2, r2;
    logic         dz;
    bit           sg;
    int           first, second, ndone;

    rst = 1'b1; start = 1'b0; flush = 1'b0; operand_1 = '0; operand_2 = '0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_div_zero", W'(div_zero), W'(0));
    check("rst_stall", W'(stall_req), W'(0));
    rst = 1'b0;

    vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,      1'b0, 1'b0});
    vecs.push_back('{32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h1234,   1'b1, 1'b0});
    vecs.push_back('{32'd50,         32'd5,          32'd10,         32'd0,      1'b0, 1'b0});
    vecs.push_back('{32'd5,          32'd10,         32'd0,          32'd5,      1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,      1'b0, 1'b0});
    vecs.push_back('{32'd0,          32'd5,          32'd0,          32'd0,      1'b0, 1'b0});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,      1'b0, 1'b1});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,      1'b0, 1'b1});
    vecs.push_back('{32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8, 1'b1, 1'b1});
`endif
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].q, vecs[i].r, vecs[i].dz);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
      sg = 1'b0;
`ifdef DIV_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`endif
      ref_div(a, b, sg, q, r, dz);
      run_op(a, b, sg, q, r, dz);
    end

    // Flush at step 10 of 50 / 5 leaves the earlier 100 / 7 result in place.
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done", W'(done), W'(0));
    check("flush_idle_stall", W'(stall_req), W'(0));
    check("flush_q_kept", quotient, 32'd14);
    check("flush_r_kept", remainder, 32'd2);
    flush = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("flush_no_done", W'(ndone), W'(0));
    run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

    // Start held high through BUSY (ignored) and DONE (accepted).
    @(negedge clk);
    operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
    first = -1; second = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        operand_1 = 32'd200;
        operand_2 = 32'd9;
      end
      if (done === 1'b1) begin
        if (first < 0) begin
          first = c; q1 = quotient; r1 = remainder;
        end else if (second < 0) begin
          second = c; q2 = quotient; r2 = remainder;
        end
      end
      if (first >= 0 && c == first + 1) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_first_cycle", W'(first), W'(33));
    check("b2b_first_q", q1, 32'd14);
    check("b2b_first_r", r1, 32'd2);
    check("b2b_second_cycle", W'(second), W'(66));
    check("b2b_second_q", q2, 32'd22);
    check("b2b_second_r", r2, 32'd2);

    // Reset at step 5, with a zero-divisor result (div_zero=1) on the outputs.
    run_op(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    @(negedge clk);
    operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_quotient", quotient, '0);
    check("mid_rst_remainder", remainder, '0);
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_div_zero", W'(div_zero), W'(0));
    check("mid_rst_stall", W'(stall_req), W'(0));
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("mid_rst_no_done", W'(ndone), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
